// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared encodings for the dmem arbiter
package dmem_arb_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_RESP = 1'b1
    } st_e;

    typedef enum logic {
        OWN_PROC = 1'b0,
        OWN_PERI = 1'b1
    } own_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear and at-max flag
module sat_counter #(
    parameter int MAX = 15
) (
    input  logic clock,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        at_max = (cnt_q == W'(MAX));
        cnt_d  = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port dmem between processor and one peripheral
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] proc_addr,
    input  logic [DW-1:0] proc_data,
    input  logic          proc_wren,
    input  logic          proc_ren,
    output logic [DW-1:0] proc_q,
    output logic          proc_stall,
    input  logic          peri_req,
    input  logic          peri_we,
    input  logic [AW-1:0] peri_addr,
    input  logic [DW-1:0] peri_wdata,
    output logic          peri_gnt,
    output logic          peri_rvalid,
    output logic [DW-1:0] peri_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q
);

    logic          proc_busy;
    logic          force_gnt;
    logic          at_max;
    own_e          owner;
    st_e           st_q, st_d;
    logic [DW-1:0] rdata_q, rdata_d;

    sat_counter #(.MAX(MAX_WAIT)) u_wait_cnt (
        .clock  (clock),
        .resetn (reset),
        .inc    (peri_req & ~peri_gnt),
        .clr    (peri_gnt | ~peri_req),
        .at_max (at_max)
    );

    // Grant and stall are masked during reset so nothing leaks out before the clearing edge.
    always_comb begin
        proc_busy  = proc_wren | proc_ren;
        force_gnt  = peri_req & at_max;
        peri_gnt   = peri_req & (~proc_busy | force_gnt) & reset;
        proc_stall = force_gnt & proc_busy & reset;
        owner      = peri_gnt ? OWN_PERI : OWN_PROC;
        proc_q     = mem_q;
        if (owner == OWN_PERI) begin
            mem_addr = peri_addr;
            mem_data = peri_wdata;
            mem_wren = peri_we & reset;
        end else begin
            mem_addr = proc_addr;
            mem_data = proc_data;
            mem_wren = proc_wren & reset;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            st_q    <= ST_IDLE;
            rdata_q <= '0;
        end else begin
            st_q    <= st_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        st_d = (peri_gnt && !peri_we) ? ST_RD_RESP : ST_IDLE;
    end

    // A read in flight when reset asserts never produces rvalid.
    always_comb begin
        peri_rvalid = (st_q == ST_RD_RESP) & reset;
        rdata_d     = peri_rvalid ? mem_q : rdata_q;
        peri_rdata  = reset ? rdata_d : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] proc_addr;
    logic [31:0] proc_data;
    logic        proc_wren, proc_ren;
    logic [31:0] proc_q;
    logic        proc_stall;
    logic        peri_req, peri_we;
    logic [11:0] peri_addr;
    logic [31:0] peri_wdata;
    logic        peri_gnt, peri_rvalid;
    logic [31:0] peri_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] mem_arr [0:4095];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) mem_arr[mem_addr] <= mem_data;
        mem_q <= mem_arr[mem_addr];
    end

    dmem_arbiter #(.AW(12), .DW(32), .MAX_WAIT(15)) dut (
        .clock       (clock),
        .reset       (reset),
        .proc_addr   (proc_addr),
        .proc_data   (proc_data),
        .proc_wren   (proc_wren),
        .proc_ren    (proc_ren),
        .proc_q      (proc_q),
        .proc_stall  (proc_stall),
        .peri_req    (peri_req),
        .peri_we     (peri_we),
        .peri_addr   (peri_addr),
        .peri_wdata  (peri_wdata),
        .peri_gnt    (peri_gnt),
        .peri_rvalid (peri_rvalid),
        .peri_rdata  (peri_rdata),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] bb_word(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    // Hold current inputs for n cycles; grant and stall expected only in cycle gnt_at.
    task automatic run_req(input int n, input int gnt_at, input string tag);
        for (int k = 1; k <= n; k++) begin
            #1;
            chk($sformatf("%s_gnt%0d", tag, k), peri_gnt, (k == gnt_at));
            chk($sformatf("%s_stall%0d", tag, k), proc_stall, (k == gnt_at));
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; proc_wren = 1'b1; proc_ren = 1'b0;
        proc_addr = 12'h005; proc_data = 32'h77;
        peri_req = 1'b0; peri_we = 1'b0; peri_addr = '0; peri_wdata = '0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_wren", mem_wren, 0);
            chk("rst_gnt", peri_gnt, 0);
            chk("rst_stall", proc_stall, 0);
            chk("rst_rvalid", peri_rvalid, 0);
            chk("rst_rdata", peri_rdata, 0);
        end
        reset = 1'b1;
        #1;
        chk("rel_wren", mem_wren, 1);
        chk("rel_addr", mem_addr, 32'h005);
        chk("rel_data", mem_data, 32'h77);
        step();

        proc_addr = 12'h010; proc_data = 32'hDEADBEEF;
        step();
        for (int i = 0; i < 4; i++) begin
            proc_addr = 12'(i); proc_data = bb_word(i);
            step();
        end
        proc_wren = 1'b0;

        proc_ren = 1'b1; proc_addr = 12'h010;
        step();
        proc_ren = 1'b0;
        #1;
        chk("proc_load", proc_q, 32'hDEADBEEF);

        // Idle slot read
        peri_req = 1'b1; peri_we = 1'b0; peri_addr = 12'h010;
        #1;
        chk("idle_gnt", peri_gnt, 1);
        chk("idle_stall", proc_stall, 0);
        chk("idle_maddr", mem_addr, 32'h010);
        step();
        peri_req = 1'b0;
        #1;
        chk("idle_rvalid", peri_rvalid, 1);
        chk("idle_rdata", peri_rdata, 32'hDEADBEEF);
        repeat (5) step();
        chk("idle_rvalid_low", peri_rvalid, 0);
        chk("idle_rdata_held", peri_rdata, 32'hDEADBEEF);

        // Starvation with continuous processor loads
        proc_ren = 1'b1; proc_addr = 12'h100;
        peri_req = 1'b1; peri_addr = 12'h011;
        run_req(16, 16, "starve1");
        run_req(16, 16, "starve2");
        run_req(10, 0, "drop_pre");
        peri_req = 1'b0;
        #1;
        chk("drop_gnt", peri_gnt, 0);
        step();
        peri_req = 1'b1;
        run_req(16, 16, "drop_post");
        peri_req = 1'b0; proc_ren = 1'b0;
        step();

        // Collision: forced peri write vs processor store to same address
        proc_ren = 1'b1; proc_addr = 12'h200;
        peri_req = 1'b1; peri_we = 1'b1; peri_addr = 12'h020; peri_wdata = 32'h1;
        run_req(15, 0, "coll_wait");
        proc_ren = 1'b0; proc_wren = 1'b1; proc_addr = 12'h020; proc_data = 32'h2;
        #1;
        chk("coll_gnt", peri_gnt, 1);
        chk("coll_stall", proc_stall, 1);
        chk("coll_maddr", mem_addr, 32'h020);
        chk("coll_mdata1", mem_data, 32'h1);
        chk("coll_wren1", mem_wren, 1);
        step();
        peri_req = 1'b0;
        #1;
        chk("coll_gnt2", peri_gnt, 0);
        chk("coll_stall2", proc_stall, 0);
        chk("coll_maddr2", mem_addr, 32'h020);
        chk("coll_mdata2", mem_data, 32'h2);
        chk("coll_wren2", mem_wren, 1);
        step();
        proc_wren = 1'b0;
        peri_req = 1'b1; peri_we = 1'b0; peri_addr = 12'h020;
        #1;
        chk("coll_rd_gnt", peri_gnt, 1);
        step();
        peri_req = 1'b0;
        #1;
        chk("coll_rd_rvalid", peri_rvalid, 1);
        chk("coll_rd_data", peri_rdata, 32'h2);
        step();

        // Back-to-back reads
        for (int i = 0; i < 4; i++) begin
            peri_req = 1'b1; peri_we = 1'b0; peri_addr = 12'(i);
            #1;
            chk($sformatf("bb_gnt%0d", i), peri_gnt, 1);
            chk($sformatf("bb_rvalid%0d", i), peri_rvalid, (i > 0));
            if (i > 0) chk($sformatf("bb_rdata%0d", i - 1), peri_rdata, bb_word(i - 1));
            step();
        end
        peri_req = 1'b0;
        #1;
        chk("bb_rvalid_last", peri_rvalid, 1);
        chk("bb_rdata3", peri_rdata, bb_word(3));
        step();
        chk("bb_rvalid_end", peri_rvalid, 0);

        // Reset in the cycle after a read grant
        peri_req = 1'b1; peri_addr = 12'h010;
        #1;
        chk("midrst_gnt", peri_gnt, 1);
        step();
        peri_req = 1'b0; reset = 1'b0;
        #1;
        chk("midrst_rvalid", peri_rvalid, 0);
        chk("midrst_rdata", peri_rdata, 0);
        step();
        reset = 1'b1;
        #1;
        chk("midrst_rvalid2", peri_rvalid, 0);
        chk("midrst_rdata2", peri_rdata, 0);
        step();

        // Reset clears a partially accumulated wait count
        proc_ren = 1'b1; proc_addr = 12'h300;
        peri_req = 1'b1; peri_addr = 12'h011;
        run_req(8, 0, "pre_rst");
        reset = 1'b0;
        #1;
        chk("wrst_gnt", peri_gnt, 0);
        chk("wrst_stall", proc_stall, 0);
        step();
        reset = 1'b1;
        run_req(16, 16, "post_rst");
        peri_req = 1'b0; proc_ren = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
